// File: rtl/window_gen_pkg.sv
// -----------------------------------------------------------------------------
// window_gen_pkg
// Shared constants and the FSM state type for the 3x3 window generator.
//   PIXEL_W  : bits per pixel
//   KERNEL   : window edge length
//   WINDOW_W : packed width of one full window
// -----------------------------------------------------------------------------
package window_gen_pkg;

    localparam int PIXEL_W  = 8;
    localparam int KERNEL   = 3;
    localparam int WINDOW_W = PIXEL_W * KERNEL * KERNEL;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } state_t;

endpackage

// File: rtl/window_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image line of storage, single port, read-before-write.
// The read is combinational, so a write at an edge still returns the
// previous contents to logic sampling on that same edge.
// Ports:
//   i_clk   : clock
//   i_we    : write enable
//   i_addr  : read/write address (pixel column)
//   i_wdata : data to store
//   o_rdata : current contents at i_addr
// -----------------------------------------------------------------------------
module line_buffer
    import window_gen_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = PIXEL_W
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_addr];

endmodule

// File: rtl/window_gen.sv
// -----------------------------------------------------------------------------
// window_gen
// Builds a sliding 3x3 pixel window from a raster-order pixel stream.
// Two line buffers hold the previous two lines; each accepted pixel pushes
// the column {row-2, row-1, current} into the right side of the window.
// Windows are emitted only when the full 3x3 neighbourhood lies inside the
// image (row >= 2 and col >= 2), one cycle after the accepting edge.
// Ports:
//   i_clk              : clock, rising edge
//   i_rst              : synchronous active-high reset
//   i_pixel_data       : input pixel
//   i_pixel_data_valid : input pixel qualifier, gaps allowed
//   o_pixel_data       : window, byte k = row*3+col, [7:0] = top-left
//   o_pixel_data_valid : window qualifier
//   o_frame_done       : pulse with the final window of a frame
// Optional: define WINDOW_GEN_FRAME_DONE_EN to enable o_frame_done,
// otherwise it is tied low.
// -----------------------------------------------------------------------------
module window_gen
    import window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [PIXEL_W-1:0]  i_pixel_data,
    input  logic                i_pixel_data_valid,
    output logic [WINDOW_W-1:0] o_pixel_data,
    output logic                o_pixel_data_valid,
    output logic                o_frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    state_t           state_q, state_d;

    logic [PIXEL_W-1:0] l1_q, l2_q;
    logic               accept, col_last, row_last, frame_last;
    logic               valid_d;

    logic [KERNEL*KERNEL-1:0][PIXEL_W-1:0] win_q, win_d;
    logic [KERNEL-1:0][PIXEL_W-1:0]        col_in;

    assign accept     = i_pixel_data_valid;
    assign col_last   = (col == COL_W'(IMG_WIDTH - 1));
    assign row_last   = (row == ROW_W'(IMG_HEIGHT - 1));
    assign frame_last = col_last && row_last;

    // L1 keeps the previous line; its old value moves to L2 on the same edge.
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_l1 (
        .i_clk   (i_clk),
        .i_we    (accept && !i_rst),
        .i_addr  (col),
        .i_wdata (i_pixel_data),
        .o_rdata (l1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_l2 (
        .i_clk   (i_clk),
        .i_we    (accept && !i_rst),
        .i_addr  (col),
        .i_wdata (l1_q),
        .o_rdata (l2_q)
    );

    always_comb begin
        col_in[0] = l2_q;
        col_in[1] = l1_q;
        col_in[2] = i_pixel_data;
        win_d     = win_q;
        for (int unsigned r = 0; r < KERNEL; r++) begin
            for (int unsigned c = 0; c < KERNEL - 1; c++) begin
                win_d[r*KERNEL + c] = win_q[r*KERNEL + c + 1];
            end
            win_d[r*KERNEL + KERNEL - 1] = col_in[r];
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = FILL;
            end
            FILL: begin
                // Last pixel of line 1 makes the next line row 2.
                if (accept && col_last && row == ROW_W'(1)) state_d = STREAM;
            end
            STREAM: begin
                valid_d = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
                if (accept && frame_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col                <= '0;
            row                <= '0;
            state_q            <= IDLE;
            win_q              <= '0;
            o_pixel_data_valid <= 1'b0;
        end else begin
            state_q            <= state_d;
            o_pixel_data_valid <= valid_d;
            if (accept) begin
                win_q <= win_d;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    assign o_pixel_data = win_q;

`ifdef WINDOW_GEN_FRAME_DONE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= accept && frame_last && (state_q == STREAM);
        end
    end
`else
    assign o_frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_window_gen.sv
// -----------------------------------------------------------------------------
// tb_window_gen
// Self-checking bench for window_gen at a 4x4 image size. A reference image
// array captures each accepted pixel at its (row, col); expected windows are
// read straight from that array.
// -----------------------------------------------------------------------------
module tb_window_gen;

    localparam int W = 4;
    localparam int H = 4;
`ifdef WINDOW_GEN_FRAME_DONE_EN
    localparam bit FD_EN = 1'b1;
`else
    localparam bit FD_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  i_pixel_data = '0;
    logic        i_pixel_data_valid = 1'b0;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_frame_done;

    window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_frame_done       (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;
    logic [71:0] exp_hold = '0;
    bit          hold_known = 1'b0;
    int          exp_windows = 0;
    int          seen_windows = 0;

    always @(negedge i_clk) if (o_pixel_data_valid === 1'b1) seen_windows++;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] v);
        logic        ev, ed;
        logic [71:0] ew;
        img[mr][mc] = v;
        ev = (mr >= 2) && (mc >= 2);
        ed = FD_EN && (mr == H - 1) && (mc == W - 1);
        ew = '0;
        if (ev) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    ew[(r*3 + c)*8 +: 8] = img[mr - 2 + r][mc - 2 + c];
        end
        i_pixel_data       = v;
        i_pixel_data_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_pixel_data_valid = 1'b0;
        chk("valid", {71'b0, o_pixel_data_valid}, {71'b0, ev});
        if (ev) begin
            chk("window", o_pixel_data, ew);
            exp_hold    = ew;
            hold_known  = 1'b1;
            exp_windows++;
        end else begin
            hold_known = 1'b0;
        end
        chk("frame_done", {71'b0, o_frame_done}, {71'b0, ed});
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("gap_valid", {71'b0, o_pixel_data_valid}, 72'b0);
            chk("gap_done", {71'b0, o_frame_done}, 72'b0);
            if (hold_known) chk("gap_hold", o_pixel_data, exp_hold);
        end
    endtask

    // Reset is asserted together with a valid pixel to exercise its priority.
    task automatic do_reset();
        i_rst              = 1'b1;
        i_pixel_data       = 8'hAA;
        i_pixel_data_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_data", o_pixel_data, 72'b0);
        chk("rst_valid", {71'b0, o_pixel_data_valid}, 72'b0);
        chk("rst_done", {71'b0, o_frame_done}, 72'b0);
        i_rst              = 1'b0;
        i_pixel_data_valid = 1'b0;
        mr = 0;
        mc = 0;
        exp_hold   = '0;
        hold_known = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        idle(2);

        // Continuous ramp frame, first window checked against fixed bytes
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            if (i == 10) chk("first_window", o_pixel_data, 72'h0a0908060504020100);
        end
        idle(2);

        // Same frame with three idle cycles after each pixel
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            idle(3);
        end

        // Two back-to-back frames; the second first window must match again
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                send(8'(i));
                if (i == 10) chk("b2b_first_window", o_pixel_data, 72'h0a0908060504020100);
            end
        end
        idle(1);

        // Reset after pixel 9, then a fresh frame
        for (int i = 0; i < 10; i++) send(8'(i));
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(100 + i));
        idle(2);

        // Random pixel values and random gaps over several frames
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) begin
                send(8'($urandom_range(0, 255)));
                idle($urandom_range(0, 3));
            end
        end

        // Random-length partial frame abandoned by reset, then a random frame
        begin
            int k;
            k = $urandom_range(1, 15);
            for (int i = 0; i < k; i++) send(8'($urandom_range(0, 255)));
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
        end
        idle(2);

        chk("window_count", 72'(seen_windows), 72'(exp_windows));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
